// File: rtl/ngy_video_pkg.sv
// Shared defaults and helpers for the grid scanout video path.
// Latency: n/a (constants, types and compile-time helpers only).
// Backpressure: n/a.
package ngy_video_pkg;

    localparam int GRID_ROWS_DEF  = 30;
    localparam int GRID_COLS_DEF  = 40;
    localparam int RAM_LENGTH_DEF = 1199;
    localparam int CELL_PX_DEF    = 8;
    localparam int PIX_DIV_DEF    = 12;

    localparam int H_ACTIVE_DEF = 320;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 32;
    localparam int H_BP_DEF     = 32;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int V_ACTIVE_DEF = 240;
    localparam int V_FP_DEF     = 4;
    localparam int V_SYNC_DEF   = 3;
    localparam int V_BP_DEF     = 13;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam logic [23:0] FG_RGB_DEF = 24'hFFFFFF;
    localparam logic [23:0] BG_RGB_DEF = 24'h000000;

    // Per-pixel raw video flags carried alongside the pixel through the pipeline.
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } vid_flags_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/ngy_video_timing.sv
// Pixel clock-enable divider plus free-running h/v counters and raw de/hs/vs flags.
// Latency: flags are combinational from the counters (pipeline stage S0).
// Backpressure: none; free-running from reset release.
module ngy_video_timing
    import ngy_video_pkg::*;
#(
    parameter int PIX_DIV      = PIX_DIV_DEF,
    parameter int H_ACTIVE     = H_ACTIVE_DEF,
    parameter int H_SYNC_START = H_ACTIVE_DEF + H_FP_DEF,
    parameter int H_TOTAL      = H_TOTAL_DEF,
    parameter int V_ACTIVE     = V_ACTIVE_DEF,
    parameter int V_SYNC_START = V_ACTIVE_DEF + V_FP_DEF,
    parameter int V_TOTAL      = V_TOTAL_DEF,
    parameter int HW           = clog2(H_TOTAL),
    parameter int VW           = clog2(V_TOTAL)
) (
    input  logic          clk_74a,
    input  logic          reset_n,
    output logic          pix_ce,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output vid_flags_t    flags,
    output logic          snap_point
);

    localparam int DW = clog2(PIX_DIV);

    logic [DW-1:0] div_cnt;

    // Pixel divider: strobe on the last count so the first strobe lands PIX_DIV clocks after reset.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (div_cnt == DW'(PIX_DIV - 1)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign pix_ce = (div_cnt == DW'(PIX_DIV - 1));

    // Raster position: h wraps into v, v wraps at the end of the frame.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_ce) begin
            if (h_cnt == HW'(H_TOTAL - 1)) begin
                h_cnt <= '0;
                if (v_cnt == VW'(V_TOTAL - 1)) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + 1'b1;
                end
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Raw flags for the current position; vs is a single pixel on the hs pixel of the sync line.
    always_comb begin
        flags.de   = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
        flags.hs   = (h_cnt == HW'(H_SYNC_START));
        flags.vs   = (h_cnt == HW'(H_SYNC_START)) && (v_cnt == VW'(V_SYNC_START));
        snap_point = (h_cnt == '0) && (v_cnt == VW'(V_ACTIVE));
    end

endmodule

// File: rtl/ngy_grid_scanout.sv
// Scans a row-major cell grid out as scaled monochrome video with per-frame snapshot.
// Latency: 2 pix_ce from counter value to rgb/de/hs/vs, all four aligned.
// Backpressure: none; video and frame_start are free-running, grid is sampled once per frame.
module ngy_grid_scanout
    import ngy_video_pkg::*;
#(
    parameter int          GRID_ROWS  = GRID_ROWS_DEF,
    parameter int          GRID_COLS  = GRID_COLS_DEF,
    parameter int          RAM_LENGTH = RAM_LENGTH_DEF,
    parameter int          CELL_PX    = CELL_PX_DEF,
    parameter int          PIX_DIV    = PIX_DIV_DEF,
    parameter int          H_ACTIVE   = H_ACTIVE_DEF,
    parameter int          H_FP       = H_FP_DEF,
    parameter int          H_SYNC     = H_SYNC_DEF,
    parameter int          H_BP       = H_BP_DEF,
    parameter int          V_ACTIVE   = V_ACTIVE_DEF,
    parameter int          V_FP       = V_FP_DEF,
    parameter int          V_SYNC     = V_SYNC_DEF,
    parameter int          V_BP       = V_BP_DEF,
    parameter logic [23:0] FG_RGB     = FG_RGB_DEF,
    parameter logic [23:0] BG_RGB     = BG_RGB_DEF
) (
    input  logic                clk_74a,
    input  logic                reset_n,
    input  logic [0:RAM_LENGTH] grid_ram,
    output logic                pix_ce,
    output logic [23:0]         video_rgb,
    output logic                video_de,
    output logic                video_hs,
    output logic                video_vs,
    output logic                frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = clog2(H_TOTAL);
    localparam int VW      = clog2(V_TOTAL);
    localparam int IW      = clog2(RAM_LENGTH + 1);
    localparam int CELL_SH = clog2(CELL_PX);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    vid_flags_t    s0_flags;
    logic          snap_point;

    ngy_video_timing #(
        .PIX_DIV      (PIX_DIV),
        .H_ACTIVE     (H_ACTIVE),
        .H_SYNC_START (H_ACTIVE + H_FP),
        .H_TOTAL      (H_TOTAL),
        .V_ACTIVE     (V_ACTIVE),
        .V_SYNC_START (V_ACTIVE + V_FP),
        .V_TOTAL      (V_TOTAL),
        .HW           (HW),
        .VW           (VW)
    ) u_timing (
        .clk_74a    (clk_74a),
        .reset_n    (reset_n),
        .pix_ce     (pix_ce),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .flags      (s0_flags),
        .snap_point (snap_point)
    );

    logic [0:RAM_LENGTH] snap;
    logic [HW-1:0]       cell_col;
    logic [VW-1:0]       cell_row;
    logic                in_grid;
    logic [IW-1:0]       cell_idx;

    // Cell coordinates via shifts; the index only matters when the pixel lies inside the grid.
    assign cell_col = h_cnt >> CELL_SH;
    assign cell_row = v_cnt >> CELL_SH;
    assign in_grid  = (32'(cell_col) < 32'(GRID_COLS)) && (32'(cell_row) < 32'(GRID_ROWS));
    assign cell_idx = IW'(cell_row) * IW'(GRID_COLS) + IW'(cell_col);

    // Freeze the grid on the first blanking line so each displayed frame is one consistent image.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            snap <= '0;
        end else if (pix_ce && snap_point) begin
            snap <= grid_ram;
        end
    end

    assign frame_start = pix_ce && snap_point;

    vid_flags_t    s1_flags;
    logic          s1_in_grid;
    logic [IW-1:0] s1_idx;

    // S1: register cell index and the raw flags so they stay aligned with the pixel.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            s1_flags   <= '0;
            s1_in_grid <= 1'b0;
            s1_idx     <= '0;
        end else if (pix_ce) begin
            s1_flags   <= s0_flags;
            s1_in_grid <= in_grid;
            s1_idx     <= in_grid ? cell_idx : '0;
        end
    end

    // S2: look up the frozen cell bit and register the visible outputs; rgb is forced to 0 in blanking.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            video_rgb <= '0;
            video_de  <= 1'b0;
            video_hs  <= 1'b0;
            video_vs  <= 1'b0;
        end else if (pix_ce) begin
            video_de <= s1_flags.de;
            video_hs <= s1_flags.hs;
            video_vs <= s1_flags.vs;
            if (!s1_flags.de) begin
                video_rgb <= '0;
            end else if (s1_in_grid && snap[s1_idx]) begin
                video_rgb <= FG_RGB;
            end else begin
                video_rgb <= BG_RGB;
            end
        end
    end

endmodule

// File: tb/tb_ngy_grid_scanout.sv
// Directed bench for ngy_grid_scanout on a scaled-down raster (6x10 grid, 2px cells, 32x20 total).
// Latency: expects video 2 pix_ce behind the raster position.
// Backpressure: n/a.
module tb_ngy_grid_scanout;

    localparam int PD   = 12;
    localparam int ROWS = 6;
    localparam int COLS = 10;
    localparam int RL   = ROWS * COLS - 1;
    localparam int CP   = 2;
    localparam int HA = 24, HFP = 2, HSY = 3, HBP = 3;
    localparam int VA = 14, VFP = 1, VSY = 2, VBP = 3;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FT = HT * VT;
    localparam int NF = 6;
    localparam int NP = 26;
    localparam logic [23:0] W = 24'hFFFFFF;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [0:RL]   grid  = '0;
    logic          pix_ce;
    logic [23:0]   video_rgb;
    logic          video_de, video_hs, video_vs, frame_start;

    ngy_grid_scanout #(
        .GRID_ROWS(ROWS), .GRID_COLS(COLS), .RAM_LENGTH(RL), .CELL_PX(CP), .PIX_DIV(PD),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .FG_RGB(24'hFFFFFF), .BG_RGB(24'h000000)
    ) dut (
        .clk_74a(clk), .reset_n(rst_n), .grid_ram(grid), .pix_ce(pix_ce),
        .video_rgb(video_rgb), .video_de(video_de), .video_hs(video_hs),
        .video_vs(video_vs), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          f;
        int          x;
        int          y;
        logic [23:0] rgb;
        logic        de;
        logic        hs;
        logic        vs;
    } probe_t;

    probe_t      probes [NP];
    logic [23:0] fb_rgb [NF][FT];
    bit          fb_de  [NF][FT];
    bit          fb_hs  [NF][FT];
    bit          fb_vs  [NF][FT];
    int          fs_cnt [NF];
    int          per_bad[NF];
    int          exp_white[NF];

    int n_checks = 0;
    int n_pass   = 0;
    int last_period;
    logic [23:0] o_rgb, pre_rgb;
    logic        o_de, o_hs, o_vs, pre_de, pre_fs;
    logic [0:RL] g0, g41, g59;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Advance one pixel: wait for pix_ce (sampled at negedge), then sample outputs after that edge.
    task automatic next_pix();
        int waits;
        waits = 0;
        while (pix_ce !== 1'b1) begin
            @(negedge clk);
            waits++;
            if (waits > 4 * PD) begin
                $display("FAIL pix_ce_timeout: no strobe within %0d cycles", 4 * PD);
                $fatal(1, "pixel strobe stalled");
            end
        end
        last_period = waits + 1;
        pre_de  = video_de;
        pre_rgb = video_rgb;
        pre_fs  = frame_start;
        @(negedge clk);
        o_rgb = video_rgb;
        o_de  = video_de;
        o_hs  = video_hs;
        o_vs  = video_vs;
    endtask

    // First two strobes after reset release: pipeline still empty, then pixel (0,0) appears.
    task automatic startup(input string tag);
        next_pix();
        chk({tag, "_first_ce_delay"}, last_period, PD);
        chk({tag, "_de_before_ce1"}, 32'(pre_de), 32'(0));
        chk({tag, "_de_after_ce1"}, 32'(o_de), 32'(0));
        chk({tag, "_rgb_after_ce1"}, 32'(o_rgb), 32'(0));
        next_pix();
        chk({tag, "_ce_period"}, last_period, PD);
        chk({tag, "_de_before_ce2"}, 32'(pre_de), 32'(0));
        chk({tag, "_rgb_before_ce2"}, 32'(pre_rgb), 32'(0));
        chk({tag, "_de_after_ce2"}, 32'(o_de), 32'(1));
    endtask

    // Record one full frame of output pixels; optionally rewrite the grid at output pixel chg_at.
    task automatic capture_frame(input int f, input int chg_at, input logic [0:RL] chg_val);
        fs_cnt[f]  = 0;
        per_bad[f] = 0;
        for (int p = 0; p < FT; p++) begin
            fb_rgb[f][p] = o_rgb;
            fb_de[f][p]  = o_de;
            fb_hs[f][p]  = o_hs;
            fb_vs[f][p]  = o_vs;
            if (p == chg_at) grid = chg_val;
            next_pix();
            if (pre_fs) fs_cnt[f]++;
            if (last_period != PD) per_bad[f]++;
        end
    endtask

    task automatic check_frame(input int f);
        int n_de, n_hs, n_vs, n_white, n_blank_bad;
        n_de = 0; n_hs = 0; n_vs = 0; n_white = 0; n_blank_bad = 0;
        for (int p = 0; p < FT; p++) begin
            if (fb_de[f][p]) n_de++;
            if (fb_hs[f][p]) n_hs++;
            if (fb_vs[f][p]) n_vs++;
            if (fb_rgb[f][p] == W) n_white++;
            if (!fb_de[f][p] && fb_rgb[f][p] != 24'h0) n_blank_bad++;
        end
        chk($sformatf("f%0d_de_pixels", f), n_de, HA * VA);
        chk($sformatf("f%0d_hs_pulses", f), n_hs, VT);
        chk($sformatf("f%0d_vs_pulses", f), n_vs, 1);
        chk($sformatf("f%0d_frame_starts", f), fs_cnt[f], 1);
        chk($sformatf("f%0d_white_pixels", f), n_white, exp_white[f]);
        chk($sformatf("f%0d_rgb_in_blank", f), n_blank_bad, 0);
        chk($sformatf("f%0d_bad_ce_periods", f), per_bad[f], 0);
    endtask

    initial begin
        // {frame, x, y, rgb, de, hs, vs}
        probes[0]  = '{0,  0,  0, 24'h0, 1'b1, 1'b0, 1'b0};
        probes[1]  = '{0, 23, 13, 24'h0, 1'b1, 1'b0, 1'b0};
        probes[2]  = '{0, 24,  0, 24'h0, 1'b0, 1'b0, 1'b0};
        probes[3]  = '{0, 26,  0, 24'h0, 1'b0, 1'b1, 1'b0};
        probes[4]  = '{0, 26, 15, 24'h0, 1'b0, 1'b1, 1'b1};
        probes[5]  = '{0, 27, 15, 24'h0, 1'b0, 1'b0, 1'b0};
        probes[6]  = '{0,  0, 14, 24'h0, 1'b0, 1'b0, 1'b0};
        probes[7]  = '{1,  0,  0, W,     1'b1, 1'b0, 1'b0};
        probes[8]  = '{1,  1,  1, W,     1'b1, 1'b0, 1'b0};
        probes[9]  = '{1,  2,  0, 24'h0, 1'b1, 1'b0, 1'b0};
        probes[10] = '{1,  0,  2, 24'h0, 1'b1, 1'b0, 1'b0};
        probes[11] = '{2, 18, 10, W,     1'b1, 1'b0, 1'b0};
        probes[12] = '{2, 19, 11, W,     1'b1, 1'b0, 1'b0};
        probes[13] = '{2, 17, 10, 24'h0, 1'b1, 1'b0, 1'b0};
        probes[14] = '{2, 18,  9, 24'h0, 1'b1, 1'b0, 1'b0};
        probes[15] = '{2, 20, 10, 24'h0, 1'b1, 1'b0, 1'b0};
        probes[16] = '{2,  2,  8, 24'h0, 1'b1, 1'b0, 1'b0};
        probes[17] = '{2,  0,  0, 24'h0, 1'b1, 1'b0, 1'b0};
        probes[18] = '{3,  2,  8, W,     1'b1, 1'b0, 1'b0};
        probes[19] = '{3,  3,  9, W,     1'b1, 1'b0, 1'b0};
        probes[20] = '{3, 19, 10, W,     1'b1, 1'b0, 1'b0};
        probes[21] = '{3, 22, 12, 24'h0, 1'b1, 1'b0, 1'b0};
        probes[22] = '{3,  0,  0, 24'h0, 1'b1, 1'b0, 1'b0};
        probes[23] = '{4,  0,  0, W,     1'b1, 1'b0, 1'b0};
        probes[24] = '{4,  2,  8, 24'h0, 1'b1, 1'b0, 1'b0};
        probes[25] = '{4, 18, 11, W,     1'b1, 1'b0, 1'b0};
        exp_white = '{0, 4, 4, 8, 8, 0};

        g0  = '0; g0[0]   = 1'b1;
        g41 = '0; g41[41] = 1'b1;
        g59 = '0; g59[59] = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_rgb", 32'(video_rgb), 32'(0));
        chk("reset_de", 32'(video_de), 32'(0));
        chk("reset_hs", 32'(video_hs), 32'(0));
        chk("reset_vs", 32'(video_vs), 32'(0));
        chk("reset_pix_ce", 32'(pix_ce), 32'(0));
        chk("reset_frame_start", 32'(frame_start), 32'(0));
        rst_n = 1'b1;
        startup("boot");

        // Frame 0: nothing snapped yet; bit 0 set before the first snapshot.
        grid = g0;
        capture_frame(0, -1, g0);
        // Frame 1 shows bit 0; grid switches to last cell only.
        capture_frame(1, 0, g59);
        // Frame 2 shows last cell; bit 41 set mid-active must stay invisible this frame.
        capture_frame(2, 6 * HT + 5, g59 | g41);
        // Frame 3 shows 59+41; clearing 41 mid-frame must not tear.
        capture_frame(3, 6 * HT + 5, g59 | g0);
        capture_frame(4, -1, g59 | g0);

        // Mid-frame reset while a white pixel is on screen.
        repeat (11 * HT + 19) next_pix();
        chk("pre_reset_rgb", 32'(o_rgb), 32'(W));
        chk("pre_reset_de", 32'(o_de), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_rgb", 32'(video_rgb), 32'(0));
        chk("async_reset_de", 32'(video_de), 32'(0));
        chk("async_reset_hs", 32'(video_hs), 32'(0));
        chk("async_reset_vs", 32'(video_vs), 32'(0));
        chk("async_reset_pix_ce", 32'(pix_ce), 32'(0));
        chk("async_reset_frame_start", 32'(frame_start), 32'(0));
        @(negedge clk);
        chk("held_reset_pix_ce", 32'(pix_ce), 32'(0));
        chk("held_reset_rgb", 32'(video_rgb), 32'(0));
        rst_n = 1'b1;
        startup("restart");
        // Snapshot was cleared: the first frame after reset is all background.
        capture_frame(5, -1, g59 | g0);

        for (int f = 0; f < NF; f++) check_frame(f);

        for (int i = 0; i < NP; i++) begin
            int pf, pi;
            pf = probes[i].f;
            pi = probes[i].y * HT + probes[i].x;
            chk($sformatf("probe%0d_rgb", i), 32'(fb_rgb[pf][pi]), 32'(probes[i].rgb));
            chk($sformatf("probe%0d_de", i), 32'(fb_de[pf][pi]), 32'(probes[i].de));
            chk($sformatf("probe%0d_hs", i), 32'(fb_hs[pf][pi]), 32'(probes[i].hs));
            chk($sformatf("probe%0d_vs", i), 32'(fb_vs[pf][pi]), 32'(probes[i].vs));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
